parking_gate_arbiter: RTL and testbench
=======================================

Name: parking_gate_arbiter

Overview:
- Controller that shares the single physical barrier gate between the entry lane and the exit lane.
- Upstream, the password FSM raises entry_req once a driver is authenticated. The exit loop sensor raises exit_req.
- The block arbitrates between the two lanes, sequences gate open / wait-for-pass / close, and maintains the lot occupancy count.
- full / empty from this block feed the lot display and block entry grants when the lot is full.

Parameters:
- CAPACITY, 8, number of parking slots; occupancy never exceeds this value.
- CNT_W, 4, occupancy counter width; must satisfy 2^CNT_W > CAPACITY.
- OPEN_CYCLES, 4, cycles spent in OPENING and in CLOSING (gate motor travel time); minimum 1.
- PASS_TIMEOUT, 16, maximum cycles spent in WAIT_PASS without car_passed before abandoning; minimum 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- entry_req  input  1  level request from entry lane; held until served.
- exit_req  input  1  level request from exit lane; held until served.
- car_passed  input  1  single-cycle pulse from the gate loop sensor: vehicle has cleared the gate.
- entry_grant  output  1  one-cycle pulse: entry lane served.
- exit_grant  output  1  one-cycle pulse: exit lane served.
- gate_open  output  1  gate motor command; 1 = open or held open.
- timeout_flag  output  1  one-cycle pulse: pass window expired with no vehicle.
- occupancy  output  CNT_W  current number of parked cars.
- full  output  1  occupancy == CAPACITY (combinational from the occupancy register).
- empty  output  1  occupancy == 0 (combinational from the occupancy register).

Behaviour:
- Reset (rst low at a rising edge):
  - State goes to IDLE, occupancy to 0, last_served to EXIT, timers to 0.
  - All pulse outputs and gate_open go to 0, so empty = 1 and full = 0 after reset.
  - Reset mid-operation takes effect at the next edge: gate_open drops immediately, there is no CLOSING phase, and occupancy is cleared.
- States: IDLE, OPENING, WAIT_PASS, CLOSING. All outputs are registered.
- Eligibility: entry is eligible when entry_req && !full; exit is eligible when exit_req && !empty.
- IDLE:
  - If exactly one lane is eligible, grant it.
  - If both are eligible, grant the lane opposite last_served, so entry wins first after reset.
  - On a grant: lane is latched in a lane register, last_served is updated, and the next state is OPENING.
  - The grant pulse (entry_grant or exit_grant) is high for exactly the first cycle of OPENING.
  - No eligible request: stay in IDLE.
- OPENING:
  - gate_open = 1.
  - Stays exactly OPEN_CYCLES cycles, then goes to WAIT_PASS.
  - Requests and car_passed are ignored.
- WAIT_PASS:
  - gate_open = 1.
  - car_passed seen: occupancy +1 for an entry, or -1 for an exit; go to CLOSING.
  - PASS_TIMEOUT cycles elapse with no car_passed: go to CLOSING with no occupancy change, and timeout_flag is high for the first CLOSING cycle.
  - car_passed in the final timeout cycle counts as a pass; the pass wins over the timeout.
- CLOSING:
  - gate_open = 0.
  - Stays exactly OPEN_CYCLES cycles, then goes to IDLE. Requests and car_passed are ignored.
- car_passed outside WAIT_PASS has no effect.
- Latency: request seen in IDLE at cycle t gives grant and gate_open at t+1; WAIT_PASS starts at t+1+OPEN_CYCLES.
- Request handling:
  - Lane choice is latched at grant, so a request dropping afterwards does not abort the cycle.
  - A request still high when the block returns to IDLE is served again.
- Occupancy arithmetic:
  - Saturates defensively at CAPACITY (increment) and at 0 (decrement).
  - Eligibility gating makes either case unreachable in normal operation.
- Occupancy changes only in WAIT_PASS on car_passed; full / empty update in the following cycle.
- A minimum of 2*OPEN_CYCLES+2 cycles separates consecutive grants.

Test Plan:
- Reset with CAPACITY=2, OPEN_CYCLES=2, PASS_TIMEOUT=4: hold rst low 2 cycles, then release -> gate_open=0, occupancy=0, empty=1, full=0, no grants.
- entry_req=1 at cycle 0, car_passed at the 2nd WAIT_PASS cycle:
  - entry_grant high at cycle 1 only; gate_open high cycles 1–4.
  - occupancy becomes 1 the cycle after car_passed; gate_open low for 2 cycles, then IDLE.
- entry_req and exit_req both held with occupancy=1, passing each time:
  - grants alternate entry, exit, entry; occupancy goes 2, 1, 2.
- Occupancy=2 (full), only entry_req=1 for 20 cycles -> no entry_grant, gate_open stays 0.
- Exit with no car_passed:
  - timeout_flag pulses once, 4 WAIT_PASS cycles after WAIT_PASS entry; occupancy is unchanged.
  - car_passed asserted on the 4th WAIT_PASS cycle instead -> no timeout_flag, occupancy decrements.
- rst driven low during WAIT_PASS with occupancy=1 -> next cycle gate_open=0, occupancy=0, state IDLE; a pending request is granted normally after release.

Source files
------------

// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: shares one barrier gate between entry/exit lanes and tracks lot occupancy
module parking_gate_arbiter #(
  parameter int CAPACITY     = 8,
  parameter int CNT_W        = 4,
  parameter int OPEN_CYCLES  = 4,
  parameter int PASS_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             car_passed,
  output logic             entry_grant,
  output logic             exit_grant,
  output logic             gate_open,
  output logic             timeout_flag,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty
);
  localparam int TMAX = (OPEN_CYCLES > PASS_TIMEOUT) ? OPEN_CYCLES : PASS_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  typedef enum logic [1:0] {IDLE, OPENING, WAIT_PASS, CLOSING} state_t;
  state_t state, state_nxt;
  logic lane, last_served;
  logic [TW-1:0] timer;
  logic entry_ok, exit_ok, pick_exit, grant, travel_done, passed, expired;
  assign full  = occupancy == CNT_W'(CAPACITY);
  assign empty = occupancy == '0;
  always_comb begin
    entry_ok    = entry_req && !full;
    exit_ok     = exit_req && !empty;
    pick_exit   = exit_ok && (!entry_ok || !last_served);
    grant       = state == IDLE && (entry_ok || exit_ok);
    travel_done = timer == TW'(OPEN_CYCLES - 1);
    passed      = state == WAIT_PASS && car_passed;
    expired     = state == WAIT_PASS && !car_passed && timer == TW'(PASS_TIMEOUT - 1);
    state_nxt   = grant                             ? OPENING   :
                  (state == OPENING && travel_done) ? WAIT_PASS :
                  (passed || expired)               ? CLOSING   :
                  (state == CLOSING && travel_done) ? IDLE      : state;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      timer        <= '0;
      lane         <= 1'b0;
      last_served  <= 1'b1;
      occupancy    <= '0;
      entry_grant  <= 1'b0;
      exit_grant   <= 1'b0;
      gate_open    <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= (state_nxt != state) ? '0 : timer + 1'b1;
      if (grant) begin
        lane        <= pick_exit;
        last_served <= pick_exit;
      end
      // lane 1 = exit; saturation is a guard, eligibility normally prevents it
      if (passed)
        occupancy <= lane ? (empty ? occupancy : occupancy - 1'b1)
                          : (full ? occupancy : occupancy + 1'b1);
      entry_grant  <= grant && !pick_exit;
      exit_grant   <= grant && pick_exit;
      gate_open    <= state_nxt == OPENING || state_nxt == WAIT_PASS;
      timeout_flag <= expired;
    end
  end
endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb_parking_gate_arbiter: scoreboard bench for the gate arbiter (CAPACITY=2, OPEN_CYCLES=2, PASS_TIMEOUT=4)
module tb_parking_gate_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic entry_req = 1'b0, exit_req = 1'b0, car_passed = 1'b0;
  logic entry_grant, exit_grant, gate_open, timeout_flag, full, empty;
  logic [3:0] occupancy;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {logic [2:0] kind; int cyc;} ev_t;
  ev_t sb[$];
  localparam logic [2:0] EV_ENTRY = 3'b100, EV_EXIT = 3'b010, EV_TMO = 3'b001;

  parking_gate_arbiter #(.CAPACITY(2), .CNT_W(4), .OPEN_CYCLES(2), .PASS_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .entry_req(entry_req), .exit_req(exit_req), .car_passed(car_passed),
    .entry_grant(entry_grant), .exit_grant(exit_grant), .gate_open(gate_open),
    .timeout_flag(timeout_flag), .occupancy(occupancy), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // pulse monitor: every grant/timeout pulse must match the head of the scoreboard
  always @(negedge clk) begin
    logic [2:0] got;
    ev_t e;
    got = {entry_grant, exit_grant, timeout_flag};
    if (got !== 3'b000 && got !== 3'bxxx) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: got %b at cycle %0d, expected none", got, cyc);
      end else begin
        e = sb.pop_front();
        if (got !== e.kind || cyc != e.cyc) begin
          miscompares++;
          $display("FAIL pulse: got %b at cycle %0d, expected %b at cycle %0d", got, cyc, e.kind, e.cyc);
        end
      end
    end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL missed_pulse: got none by cycle %0d, expected %b at cycle %0d", cyc, sb[0].kind, sb[0].cyc);
      void'(sb.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    vectors++;
    if ({gate_open, occupancy, empty, full} !== {1'b0, 4'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got gate=%b occ=%0d empty=%b full=%b, expected 0 0 1 0", gate_open, occupancy, empty, full);
    end
    vectors++;
    if ({entry_grant, exit_grant, timeout_flag} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_pulses: got %b expected 000", {entry_grant, exit_grant, timeout_flag});
    end
  endtask

  task automatic test_entry;
    int t = cyc;
    entry_req = 1'b1;
    sb.push_back('{EV_ENTRY, t + 1});
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      entry_req = 1'b0;
      if (k == 4) car_passed = 1'b1;
      vectors++;
      if (gate_open !== 1'b1) begin
        miscompares++;
        $display("FAIL entry_gate_open_c%0d: got %b expected 1", k, gate_open);
      end
    end
    tick(1);
    car_passed = 1'b0;
    vectors++;
    if ({gate_open, occupancy, empty} !== {1'b0, 4'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL entry_after_pass: got gate=%b occ=%0d empty=%b, expected 0 1 0", gate_open, occupancy, empty);
    end
    tick(1);
    vectors++;
    if (gate_open !== 1'b0) begin
      miscompares++;
      $display("FAIL entry_closing: got gate=%b expected 0", gate_open);
    end
    tick(2);
  endtask

  task automatic test_exit_timeout;
    int t = cyc;
    exit_req = 1'b1;
    sb.push_back('{EV_EXIT, t + 1});
    sb.push_back('{EV_TMO, t + 7});
    tick(1);
    exit_req = 1'b0;
    tick(6);
    vectors++;
    if ({gate_open, occupancy} !== {1'b0, 4'd1}) begin
      miscompares++;
      $display("FAIL timeout_state: got gate=%b occ=%0d, expected 0 1", gate_open, occupancy);
    end
    tick(3);
  endtask

  task automatic test_back_to_back;
    int t = cyc;
    entry_req = 1'b1;
    exit_req = 1'b1;
    sb.push_back('{EV_ENTRY, t + 1});
    sb.push_back('{EV_EXIT, t + 7});
    sb.push_back('{EV_ENTRY, t + 13});
    tick(3); car_passed = 1'b1;
    tick(1); car_passed = 1'b0;
    vectors++;
    if ({occupancy, full} !== {4'd2, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_first: got occ=%0d full=%b, expected 2 1", occupancy, full);
    end
    tick(5); car_passed = 1'b1;
    tick(1); car_passed = 1'b0;
    vectors++;
    if ({occupancy, full} !== {4'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_second: got occ=%0d full=%b, expected 1 0", occupancy, full);
    end
    tick(3);
    entry_req = 1'b0;
    exit_req = 1'b0;
    tick(2); car_passed = 1'b1;
    tick(1); car_passed = 1'b0;
    vectors++;
    if ({occupancy, full} !== {4'd2, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_third: got occ=%0d full=%b, expected 2 1", occupancy, full);
    end
    tick(3);
  endtask

  task automatic test_full_blocks_entry;
    entry_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      vectors++;
      if (gate_open !== 1'b0) begin
        miscompares++;
        $display("FAIL full_gate_c%0d: got %b expected 0", k, gate_open);
      end
    end
    entry_req = 1'b0;
  endtask

  task automatic test_pass_on_last_cycle;
    int t = cyc;
    exit_req = 1'b1;
    sb.push_back('{EV_EXIT, t + 1});
    tick(1);
    exit_req = 1'b0;
    tick(5);
    vectors++;
    if (gate_open !== 1'b1) begin
      miscompares++;
      $display("FAIL last_cycle_gate: got %b expected 1", gate_open);
    end
    car_passed = 1'b1;
    tick(1);
    car_passed = 1'b0;
    vectors++;
    if ({gate_open, occupancy, full} !== {1'b0, 4'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL last_cycle_pass: got gate=%b occ=%0d full=%b, expected 0 1 0", gate_open, occupancy, full);
    end
    tick(3);
  endtask

  task automatic test_reset_mid;
    int t = cyc;
    entry_req = 1'b1;
    sb.push_back('{EV_ENTRY, t + 1});
    tick(3);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    vectors++;
    if ({gate_open, occupancy, empty} !== {1'b0, 4'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL mid_reset: got gate=%b occ=%0d empty=%b, expected 0 0 1", gate_open, occupancy, empty);
    end
    sb.push_back('{EV_ENTRY, t + 5});
    tick(1);
    entry_req = 1'b0;
    vectors++;
    if (gate_open !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_regrant_gate: got %b expected 1", gate_open);
    end
    tick(2); car_passed = 1'b1;
    tick(1); car_passed = 1'b0;
    vectors++;
    if (occupancy !== 4'd1) begin
      miscompares++;
      $display("FAIL mid_regrant_occ: got %0d expected 1", occupancy);
    end
    tick(3);
  endtask

  initial begin
    test_reset;
    test_entry;
    test_exit_timeout;
    test_back_to_back;
    test_full_blocks_entry;
    test_pass_on_last_cycle;
    test_reset_mid;
    tick(3);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending events, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
